// File: rtl/cp0_access_unit.sv
// Serialised, non-speculative MTC0/MFC0 executor: resolves the operand, waits for ROB head, does one CP0 access.
// Optional macro CP0_RD_BYPASS_EN returns the access result combinationally in the cp0_ack cycle.
module cp0_access_unit #(
  parameter int TAG_WIDTH = 6,
  parameter int ROB_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_cp0_addr,
  input  logic                 in_read_flag,
  input  logic                 in_write_flag,
  input  logic                 in_write_is_ref,
  input  logic [31:0]          in_write_data,
  input  logic [ROB_WIDTH-1:0] in_rob_id,
  input  logic                 bcast_valid,
  input  logic [TAG_WIDTH-1:0] bcast_tag,
  input  logic [31:0]          bcast_data,
  input  logic                 head_valid,
  input  logic [ROB_WIDTH-1:0] head_rob_id,
  input  logic                 flush,
  output logic                 cp0_req,
  output logic                 cp0_we,
  output logic [7:0]           cp0_addr,
  output logic [31:0]          cp0_wdata,
  input  logic                 cp0_ack,
  input  logic [31:0]          cp0_rdata,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROB_WIDTH-1:0] res_rob_id,
  output logic [31:0]          res_data,
  output logic                 res_is_read
);

  typedef enum logic [2:0] {IDLE, WAIT_OPND, WAIT_HEAD, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             addr_q, addr_d;
  logic                   we_q, we_d;
  logic [ROB_WIDTH-1:0]   rob_q, rob_d;
  logic [31:0]            data_q, data_d;   // operand/tag before access, read data after
  logic                   drop_q, drop_d;

  logic in_hit, opnd_hit, head_hit, byp_valid;

  assign in_hit   = bcast_valid && (bcast_tag == in_write_data[TAG_WIDTH-1:0]);
  assign opnd_hit = bcast_valid && (bcast_tag == data_q[TAG_WIDTH-1:0]);
  assign head_hit = head_valid && (head_rob_id == rob_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rob_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rob_q   <= rob_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rob_d   = rob_q;
    data_d  = data_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!flush && in_valid && (in_read_flag || in_write_flag)) begin
          addr_d = in_cp0_addr;
          we_d   = in_write_flag;
          rob_d  = in_rob_id;
          data_d = in_write_data;
          if (in_write_flag && in_write_is_ref) begin
            if (in_hit) begin
              data_d  = bcast_data;
              state_d = WAIT_HEAD;
            end else begin
              state_d = WAIT_OPND;
            end
          end else begin
            state_d = WAIT_HEAD;
          end
        end
      end
      WAIT_OPND: begin
        if (flush) begin
          state_d = IDLE;
        end else if (opnd_hit) begin
          data_d  = bcast_data;
          state_d = WAIT_HEAD;
        end
      end
      WAIT_HEAD: begin
        if (flush)         state_d = IDLE;
        else if (head_hit) state_d = ACCESS;
      end
      ACCESS: begin
        // The CP0 side effect cannot be cancelled, so a flush only marks the result as dropped.
        if (flush) drop_d = 1'b1;
        if (cp0_ack) begin
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            if (!we_q) data_d = cp0_rdata;
`ifdef CP0_RD_BYPASS_EN
            state_d = res_ready ? IDLE : RESP;
`else
            state_d = RESP;
`endif
          end
        end
      end
      RESP: begin
        if (flush || res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CP0_RD_BYPASS_EN
  assign byp_valid = (state_q == ACCESS) && cp0_ack && !drop_q && !flush;
`else
  assign byp_valid = 1'b0;
`endif

  always_comb begin
    in_ready    = rst && (state_q == IDLE);
    cp0_req     = (state_q == ACCESS);
    cp0_we      = cp0_req && we_q;
    cp0_addr    = addr_q;
    cp0_wdata   = data_q;
    res_valid   = (state_q == RESP) || byp_valid;
    res_rob_id  = rob_q;
    res_is_read = res_valid && !we_q;
    res_data    = 32'h0;
    if (byp_valid && !we_q)                res_data = cp0_rdata;
    else if (state_q == RESP && !we_q)     res_data = data_q;
  end

endmodule

// File: tb/tb_cp0_access_unit.sv
// Bench for cp0_access_unit: directed scenarios plus randomized transactions against a transaction-level model.
// Honours CP0_RD_BYPASS_EN for result timing expectations.
module tb_cp0_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, in_read_flag, in_write_flag, in_write_is_ref;
  logic [7:0]  in_cp0_addr;
  logic [31:0] in_write_data;
  logic [5:0]  in_rob_id;
  logic        bcast_valid;
  logic [5:0]  bcast_tag;
  logic [31:0] bcast_data;
  logic        head_valid;
  logic [5:0]  head_rob_id;
  logic        flush;
  logic        cp0_req, cp0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_ack = 1'b0;
  logic [31:0] cp0_rdata = 32'h0;
  logic        res_valid, res_ready, res_is_read;
  logic [5:0]  res_rob_id;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;

`ifdef CP0_RD_BYPASS_EN
  localparam int RES_CYC = 2;
`else
  localparam int RES_CYC = 3;
`endif

  cp0_access_unit #(.TAG_WIDTH(6), .ROB_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cp0_addr(in_cp0_addr),
    .in_read_flag(in_read_flag), .in_write_flag(in_write_flag),
    .in_write_is_ref(in_write_is_ref), .in_write_data(in_write_data), .in_rob_id(in_rob_id),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag), .bcast_data(bcast_data),
    .head_valid(head_valid), .head_rob_id(head_rob_id), .flush(flush),
    .cp0_req(cp0_req), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_ack(cp0_ack), .cp0_rdata(cp0_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_rob_id(res_rob_id),
    .res_data(res_data), .res_is_read(res_is_read)
  );

  always #5 clk = ~clk;

  // CP0 register file: acks after ack_lat extra cycles of cp0_req.
  logic [31:0] slave_regs [256];
  logic [31:0] model_regs [256];
  int ack_lat = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!cp0_req) begin
      cp0_ack = 1'b0;
      acc_cnt = 0;
    end else begin
      if (acc_cnt == ack_lat) begin
        cp0_ack   = 1'b1;
        cp0_rdata = slave_regs[cp0_addr];
        if (cp0_we) slave_regs[cp0_addr] = cp0_wdata;
      end else begin
        cp0_ack = 1'b0;
      end
      acc_cnt++;
    end
  end

  typedef struct packed {logic we; logic [7:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct packed {logic [5:0] rob; logic [31:0] data; logic rd;} res_t;
  acc_t acc_q[$];
  res_t res_q[$];

  always @(negedge clk) begin
    if (rst && cp0_req && cp0_ack) acc_q.push_back({cp0_we, cp0_addr, cp0_wdata});
    if (rst && res_valid && res_ready) res_q.push_back({res_rob_id, res_data, res_is_read});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_read_flag = 0; in_write_flag = 0; in_write_is_ref = 0;
    in_cp0_addr = 0; in_write_data = 0; in_rob_id = 0;
    bcast_valid = 0; bcast_tag = 0; bcast_data = 0;
    head_valid = 0; head_rob_id = 0; flush = 0; res_ready = 1;
  endtask

  task automatic offer(input logic rd, input logic wr, input logic isref, input logic [7:0] a,
                       input logic [31:0] d, input logic [5:0] r);
    in_valid = 1; in_read_flag = rd; in_write_flag = wr; in_write_is_ref = isref;
    in_cp0_addr = a; in_write_data = d; in_rob_id = r;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++;
    if ({cp0_req, cp0_we, cp0_addr, cp0_wdata, res_valid, res_rob_id, res_data, res_is_read} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%0b addr=%h res_valid=%0b data=%h exp all 0",
                         cp0_req, cp0_addr, res_valid, res_data);
    end
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_min_latency();
    slave_regs[8'h60] = 32'h1040FF01; model_regs[8'h60] = 32'h1040FF01;
    ack_lat = 0; head_valid = 1; head_rob_id = 6'd5; res_ready = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) offer(1, 0, 0, 8'h60, $urandom, 6'd5); else in_valid = 0;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready0 got %0b exp 1", in_ready); end
      end
      if (c == 1) begin
        checks++;
        if (in_ready !== 1'b0 || cp0_req !== 1'b0) begin
          errors++; $display("FAIL lat_cycle1 got ready=%0b req=%0b exp 0 0", in_ready, cp0_req);
        end
      end
      if (c == 2) begin
        checks++;
        if (cp0_req !== 1'b1 || cp0_we !== 1'b0 || cp0_addr !== 8'h60) begin
          errors++; $display("FAIL lat_access got req=%0b we=%0b addr=%h exp 1 0 60", cp0_req, cp0_we, cp0_addr);
        end
      end
      checks++;
      if (res_valid !== 1'(c == RES_CYC)) begin
        errors++; $display("FAIL lat_res_valid_c%0d got %0b exp %0b", c, res_valid, c == RES_CYC);
      end
      if (c == RES_CYC) begin
        checks++;
        if (res_rob_id !== 6'd5 || res_data !== 32'h1040FF01 || res_is_read !== 1'b1) begin
          errors++; $display("FAIL lat_res_fields got rob=%0d data=%h rd=%0b exp 5 1040ff01 1",
                             res_rob_id, res_data, res_is_read);
        end
      end
      if (c == 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_back_idle got %0b exp 1", in_ready); end
      end
      tick();
    end
    $display("txn min_latency mfc0 addr=60 rob=5");
    idle_inputs(); acc_q.delete(); res_q.delete();
  endtask

  task automatic test_ref_wait();
    ack_lat = 0; head_valid = 1; head_rob_id = 6'd9; res_ready = 1;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) offer(0, 1, 1, 8'h68, {$urandom} & 32'hFFFF_FFC0 | 32'h12, 6'd9); else in_valid = 0;
      bcast_valid = 1; bcast_tag = (c == 4) ? 6'h12 : 6'h13; bcast_data = (c == 4) ? 32'h300 : $urandom;
      if (c > 4) bcast_valid = 0;
      @(negedge clk);
      if (c <= 5) begin
        checks++;
        if (cp0_req !== 1'b0) begin errors++; $display("FAIL refw_early_req_c%0d got %0b exp 0", c, cp0_req); end
      end
      if (c == 6) begin
        checks++;
        if (cp0_req !== 1'b1 || cp0_we !== 1'b1 || cp0_addr !== 8'h68 || cp0_wdata !== 32'h300) begin
          errors++; $display("FAIL refw_access got req=%0b we=%0b addr=%h wdata=%h exp 1 1 68 00000300",
                             cp0_req, cp0_we, cp0_addr, cp0_wdata);
        end
      end
      if (c == 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL refw_idle got %0b exp 1", in_ready); end
      end
      tick();
    end
    model_regs[8'h68] = 32'h300;
    checks++;
    if (res_q.size() != 1 || res_q[0] !== {6'd9, 32'h0, 1'b0}) begin
      errors++; $display("FAIL refw_result got n=%0d exp one write completion rob 9", res_q.size());
    end
    $display("txn ref_wait mtc0 addr=68 tag=12");
    idle_inputs(); acc_q.delete(); res_q.delete();
  endtask

  task automatic test_same_cycle_bcast();
    logic [31:0] v;
    v = $urandom;
    ack_lat = 1; head_valid = 1; head_rob_id = 6'd20; res_ready = 1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        offer(0, 1, 1, 8'h70, 32'h0000_AB07, 6'd20);
        bcast_valid = 1; bcast_tag = 6'h07; bcast_data = v;
      end else begin
        in_valid = 0; bcast_valid = 0;
      end
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (cp0_req !== 1'b0) begin errors++; $display("FAIL same_c1_req got %0b exp 0", cp0_req); end
      end
      if (c == 2) begin
        checks++;
        if (cp0_req !== 1'b1 || cp0_we !== 1'b1 || cp0_wdata !== v) begin
          errors++; $display("FAIL same_access got req=%0b we=%0b wdata=%h exp 1 1 %h", cp0_req, cp0_we, cp0_wdata, v);
        end
      end
      tick();
    end
    model_regs[8'h70] = v;
    checks++;
    if (in_ready !== 1'b1 || acc_q.size() != 1) begin
      errors++; $display("FAIL same_done got ready=%0b accesses=%0d exp 1 1", in_ready, acc_q.size());
    end
    $display("txn same_cycle_bcast mtc0 addr=70 tag=07");
    idle_inputs(); acc_q.delete(); res_q.delete();
  endtask

  task automatic test_flush_wait_head();
    ack_lat = 0; head_valid = 1; head_rob_id = 6'd4; res_ready = 1;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) offer(1, 0, 0, 8'h10, 32'h0, 6'd3); else in_valid = 0;
      flush = (c == 11);
      if (c >= 12) head_rob_id = 6'd3;
      @(negedge clk);
      checks++;
      if (cp0_req !== 1'b0 || res_valid !== 1'b0) begin
        errors++; $display("FAIL fwh_quiet_c%0d got req=%0b res_valid=%0b exp 0 0", c, cp0_req, res_valid);
      end
      if (c == 11 || c == 12) begin
        checks++;
        if (in_ready !== 1'(c == 12)) begin
          errors++; $display("FAIL fwh_ready_c%0d got %0b exp %0b", c, in_ready, c == 12);
        end
      end
      tick();
    end
    checks++;
    if (acc_q.size() != 0 || res_q.size() != 0) begin
      errors++; $display("FAIL fwh_nothing got acc=%0d res=%0d exp 0 0", acc_q.size(), res_q.size());
    end
    $display("txn flush_wait_head mfc0 rob=3");
    idle_inputs(); acc_q.delete(); res_q.delete();
  endtask

  task automatic test_flush_access();
    int req_cycles;
    req_cycles = 0;
    ack_lat = 2; head_valid = 1; head_rob_id = 6'd7; res_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) offer(1, 0, 0, 8'h78, 32'h0, 6'd7); else in_valid = 0;
      flush = (c == 2);
      @(negedge clk);
      if (cp0_req) req_cycles++;
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL facc_res_valid_c%0d got %0b exp 0", c, res_valid); end
      if (c == 5) begin
        checks++;
        if (in_ready !== 1'b1 || cp0_req !== 1'b0) begin
          errors++; $display("FAIL facc_idle got ready=%0b req=%0b exp 1 0", in_ready, cp0_req);
        end
      end
      tick();
    end
    checks++;
    if (req_cycles != 3) begin errors++; $display("FAIL facc_req_cycles got %0d exp 3", req_cycles); end
    checks++;
    if (acc_q.size() != 1 || res_q.size() != 0) begin
      errors++; $display("FAIL facc_counts got acc=%0d res=%0d exp 1 0", acc_q.size(), res_q.size());
    end
    $display("txn flush_access mfc0 addr=78 rob=7");
    idle_inputs(); acc_q.delete(); res_q.delete(); ack_lat = 0;
  endtask

  task automatic test_resp_stall();
    logic [31:0] exp_d;
    exp_d = model_regs[8'h4A];
    ack_lat = 0; head_valid = 1; head_rob_id = 6'd33; res_ready = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) offer(1, 0, 0, 8'h4A, 32'h0, 6'd33); else in_valid = 0;
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp_d || res_rob_id !== 6'd33 || res_is_read !== 1'b1) begin
          errors++; $display("FAIL stall_hold_c%0d got v=%0b data=%h rob=%0d exp 1 %h 33", c, res_valid, res_data,
                             res_rob_id, exp_d);
        end
      end
      tick();
    end
    rst = 0;
    #1;
    checks++;
    if ({in_ready, cp0_req, cp0_we, cp0_addr, cp0_wdata, res_valid, res_rob_id, res_data, res_is_read} !== '0) begin
      errors++; $display("FAIL stall_reset got ready=%0b v=%0b rob=%0d data=%h addr=%h exp all 0",
                         in_ready, res_valid, res_rob_id, res_data, cp0_addr);
    end
    tick();
    rst = 1;
    idle_inputs();
    tick();
    checks++;
    if (res_q.size() != 0) begin errors++; $display("FAIL stall_no_handshake got %0d exp 0", res_q.size()); end
    $display("txn resp_stall mfc0 addr=4a rob=33");
    acc_q.delete(); res_q.delete();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic rd, wr, isref, fired, done;
      logic [7:0] a;
      logic [5:0] r, tg;
      logic [31:0] d, rv, exp_w, exp_r;
      int bdly, hdly, cyc, exp_n;
      acc_t a0;
      res_t r0;
      rd = 1'($urandom); wr = 1'($urandom); isref = wr & 1'($urandom);
      a = 8'($urandom); r = 6'($urandom); tg = 6'($urandom); rv = $urandom;
      d = ($urandom & 32'hFFFF_FFC0) | {26'h0, tg};
      bdly = $urandom_range(0, 4); hdly = $urandom_range(0, 5); ack_lat = $urandom_range(0, 3);
      exp_n = (rd || wr) ? 1 : 0;
      exp_w = isref ? rv : d;
      exp_r = model_regs[a];
      fired = 0; done = 0; cyc = 0;
      while (!done && cyc < 100) begin
        if (cyc == 0) offer(rd, wr, isref, a, d, r); else in_valid = 0;
        if (isref && !fired && cyc >= bdly) begin
          bcast_valid = 1; bcast_tag = tg; bcast_data = rv; fired = 1;
        end else begin
          bcast_valid = 1'($urandom); bcast_tag = tg ^ 6'($urandom_range(1, 63)); bcast_data = $urandom;
        end
        if (cyc >= hdly) begin
          head_valid = 1; head_rob_id = r;
        end else begin
          head_valid = 1'($urandom); head_rob_id = r ^ 6'($urandom_range(1, 63));
        end
        res_ready = 1'($urandom);
        @(negedge clk);
        if (cyc == 1 && exp_n == 1) begin
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got %0b exp 0", t, in_ready); end
        end
        if (cyc > 0 && in_ready) done = 1;
        tick();
        cyc++;
      end
      idle_inputs();
      tick();
      checks++;
      if (!done) begin errors++; $display("FAIL rnd%0d_timeout got busy after %0d cycles exp idle", t, cyc); end
      if (wr) model_regs[a] = exp_w;
      checks++;
      if (acc_q.size() != exp_n) begin
        errors++; $display("FAIL rnd%0d_acc_count got %0d exp %0d", t, acc_q.size(), exp_n);
      end else if (exp_n == 1) begin
        a0 = acc_q[0];
        checks++;
        if (a0.we !== wr || a0.addr !== a || (wr && a0.wdata !== exp_w)) begin
          errors++; $display("FAIL rnd%0d_access got we=%0b addr=%h wdata=%h exp %0b %h %h", t, a0.we, a0.addr,
                             a0.wdata, wr, a, exp_w);
        end
      end
      checks++;
      if (res_q.size() != exp_n) begin
        errors++; $display("FAIL rnd%0d_res_count got %0d exp %0d", t, res_q.size(), exp_n);
      end else if (exp_n == 1) begin
        r0 = res_q[0];
        checks++;
        if (r0.rob !== r || r0.data !== (wr ? 32'h0 : exp_r) || r0.rd !== !wr) begin
          errors++; $display("FAIL rnd%0d_result got rob=%0d data=%h rd=%0b exp %0d %h %0b", t, r0.rob, r0.data,
                             r0.rd, r, wr ? 32'h0 : exp_r, !wr);
        end
      end
      $display("txn rnd%0d rd=%0b wr=%0b ref=%0b addr=%h rob=%0d cycles=%0d", t, rd, wr, isref, a, r, cyc);
      acc_q.delete(); res_q.delete();
    end
  endtask

  initial begin
    logic [31:0] v;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_regs[i] = v;
      model_regs[i] = v;
    end
    test_reset();
    test_min_latency();
    test_ref_wait();
    test_same_cycle_bcast();
    test_flush_wait_head();
    test_flush_access();
    test_resp_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
